// File: rtl/key_repeat.sv
// Key auto-repeat generator: turns debounced key levels into one-cycle command
// strobes, with a first-repeat delay and a steady repeat rate for masked keys.
module key_repeat #(
    parameter logic [15:0] DELAY       = 16'd300,
    parameter logic [15:0] RATE        = 16'd60,
    parameter logic [3:0]  REPEAT_MASK = 4'b0111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] held,
    output logic [3:0] pulse,
    output logic [1:0] active,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT,
        ST_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  pulse_q, pulse_d;
    logic [1:0]  active_q, active_d;
    logic        busy_q, busy_d;
    logic [1:0]  press_idx;
    logic [3:0]  active_onehot;

    // Highest-numbered key wins a simultaneous press (rotate > down > right > left).
    always_comb begin
        press_idx = 2'd0;
        if (held[3])      press_idx = 2'd3;
        else if (held[2]) press_idx = 2'd2;
        else if (held[1]) press_idx = 2'd1;
    end

    assign active_onehot = 4'b0001 << active_q;

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pulse_d  = 4'b0000;
        active_d = active_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (held != 4'b0000) begin
                    active_d = press_idx;
                    pulse_d  = 4'b0001 << press_idx;
                    state_d  = REPEAT_MASK[press_idx] ? ST_DELAY : ST_HOLD;
                end
            end
            ST_DELAY: begin
                // Release is checked before the timeout so a late release never repeats.
                if (!held[active_q]) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == DELAY - 16'd1) begin
                    pulse_d = active_onehot;
                    cnt_d   = 16'd0;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_REPEAT: begin
                if (!held[active_q]) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == RATE - 16'd1) begin
                    pulse_d = active_onehot;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_HOLD: begin
                if (!held[active_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            pulse_q  <= 4'b0000;
            active_q <= 2'b00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            active_q <= active_d;
            busy_q   <= busy_d;
        end
    end

    assign pulse  = pulse_q;
    assign active = active_q;
    assign busy   = busy_q;

endmodule

// File: doc/key_repeat.md
KEY_REPEAT -- requirements
Module: key_repeat

Interface
REQ-001 Parameter DELAY, 16'd300: clk cycles from the first pulse to the first repeat pulse; legal range 2..65535.
REQ-002 Parameter RATE, 16'd60: clk cycles between successive repeat pulses; legal range 2..65535.
REQ-003 Parameter REPEAT_MASK, 4'b0111: bit i=1 means key i auto-repeats; bit i=0 means key i gives one pulse per press.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 held  input  4  debounced key levels, 1=pressed; [0]=left, [1]=right, [2]=down, [3]=rotate.
REQ-007 pulse  output  4  registered one-cycle command strobes; at most one bit high in any cycle.
REQ-008 active  output  2  registered index of the key being tracked; valid only while busy=1.
REQ-009 busy  output  1  registered; high whenever the FSM is not in IDLE.

Function
REQ-010 The FSM SHALL have the states IDLE, DELAY, REPEAT and HOLD, plus a 16-bit cycle counter cnt.
REQ-011 IDLE with held!=0: on this edge, latch active as the highest-set index (priority 3>2>1>0), set pulse[active]=1 and clear cnt.
REQ-012 In that same IDLE transition, go to DELAY if REPEAT_MASK[active]=1, otherwise go to HOLD.
REQ-013 Latency: with held sampled nonzero at edge N in IDLE, pulse is high between edges N and N+1 and low after edge N+1.
REQ-014 IDLE with held==0: pulse=0, cnt=0, state unchanged.
REQ-015 DELAY: if held[active]=0, go to IDLE and emit no pulse.
REQ-016 DELAY: otherwise, when cnt==DELAY-1, set pulse[active]=1, clear cnt and go to REPEAT; else cnt+=1.
REQ-017 REPEAT: if held[active]=0, go to IDLE with no pulse.
REQ-018 REPEAT: otherwise, when cnt==RATE-1, set pulse[active]=1 and clear cnt; else cnt+=1.
REQ-019 HOLD: stay until held[active]=0, then go to IDLE; no pulses are issued while in HOLD.
REQ-020 While busy=1, changes on held bits other than active SHALL be ignored: no preemption and no pulses.
REQ-021 Release and re-press: after returning to IDLE, any key still held SHALL be accepted on the next edge per REQ-011, giving at least one cycle of pulse=0 between presses.
REQ-022 Release check vs. timeout: release has priority; held[active]=0 on the same edge as cnt reaching its limit SHALL give IDLE with no pulse.
REQ-023 Timing: first repeat pulse is DELAY cycles after the first pulse; later repeat pulses are RATE cycles apart.
REQ-024 pulse SHALL be cleared on every edge on which REQ-011, REQ-016 or REQ-018 does not set it.
REQ-025 cnt SHALL never wrap: it is compared against its limit, and the limit is at most 65535.

Reset
REQ-026 rst=0 SHALL immediately and asynchronously force state=IDLE, cnt=0, pulse=4'b0000, active=2'b00, busy=0.
REQ-027 Reset asserted mid-repeat: no pulse is emitted during reset or on the first edge after rst rises unless held is nonzero at that edge.
REQ-028 If held is nonzero at the first edge after rst rises, that edge SHALL be treated as a fresh press (REQ-011).
REQ-029 held is already synchronous and debounced; the block SHALL add no input synchronizers.

Verification (bench overrides: DELAY=4, RATE=2, REPEAT_MASK=4'b0111)
REQ-030 Tap: held=4'b0001 for 3 cycles, then 0 -> exactly one pulse=4'b0001, one cycle after the press edge; busy low again after release.
REQ-031 Hold left 12 cycles -> pulse[0] high at cycle offsets 1, 5, 7, 9, 11 (relative to the press edge), pulse low at all other offsets.
REQ-032 Rotate held 10 cycles -> single pulse=4'b1000; busy=1 until release; no further pulses.
REQ-033 Left held, then right also pressed at offset 3, then left released at offset 6 with right still held -> right's first pulse at offset 8, and active=2'b01 from then on.
REQ-034 Simultaneous press held=4'b0110 -> pulse=4'b0100 (down wins); active=2'b10.
REQ-035 Reset pulse at offset 6 while left is held in REPEAT -> pulse=0 and busy=0 during reset; fresh pulse[0] one cycle after the first post-reset edge.
